// File: rtl/morse_pkg.sv
// Shared types, timing constants and the ASCII-to-Morse lookup for the keyer.
// Codes are left-aligned in a 5-bit field: element 0 sits in bits[4], 1 = dash.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MARK     = 3'd1,
    ST_GAP_ELEM = 3'd2,
    ST_GAP_CHAR = 3'd3,
    ST_GAP_WORD = 3'd4
  } morse_state_e;

  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int ELEM_GAP_UNITS   = 1;
  localparam int CHAR_GAP_UNITS   = 3;
  localparam int WORD_EXTRA_UNITS = 4;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] bits;
  } morse_code_t;

  typedef struct packed {
    logic        valid;
    morse_code_t code;
  } morse_lookup_t;

  // Space returns valid with len 0; unsupported characters return valid 0.
  function automatic morse_lookup_t morse_lookup(input logic [7:0] ch);
    morse_lookup_t res;
    logic [7:0]    up;
    res = '0;
    res.valid = 1'b1;
    if ((ch >= 8'h61) && (ch <= 8'h7A)) begin
      up = ch - 8'h20;
    end else begin
      up = ch;
    end
    case (up)
      8'h20: res.code = {3'd0, 5'b00000};
      8'h41: res.code = {3'd2, 5'b01000}; // A .-
      8'h42: res.code = {3'd4, 5'b10000}; // B -...
      8'h43: res.code = {3'd4, 5'b10100}; // C -.-.
      8'h44: res.code = {3'd3, 5'b10000}; // D -..
      8'h45: res.code = {3'd1, 5'b00000}; // E .
      8'h46: res.code = {3'd4, 5'b00100}; // F ..-.
      8'h47: res.code = {3'd3, 5'b11000}; // G --.
      8'h48: res.code = {3'd4, 5'b00000}; // H ....
      8'h49: res.code = {3'd2, 5'b00000}; // I ..
      8'h4A: res.code = {3'd4, 5'b01110}; // J .---
      8'h4B: res.code = {3'd3, 5'b10100}; // K -.-
      8'h4C: res.code = {3'd4, 5'b01000}; // L .-..
      8'h4D: res.code = {3'd2, 5'b11000}; // M --
      8'h4E: res.code = {3'd2, 5'b10000}; // N -.
      8'h4F: res.code = {3'd3, 5'b11100}; // O ---
      8'h50: res.code = {3'd4, 5'b01100}; // P .--.
      8'h51: res.code = {3'd4, 5'b11010}; // Q --.-
      8'h52: res.code = {3'd3, 5'b01000}; // R .-.
      8'h53: res.code = {3'd3, 5'b00000}; // S ...
      8'h54: res.code = {3'd1, 5'b10000}; // T -
      8'h55: res.code = {3'd3, 5'b00100}; // U ..-
      8'h56: res.code = {3'd4, 5'b00010}; // V ...-
      8'h57: res.code = {3'd3, 5'b01100}; // W .--
      8'h58: res.code = {3'd4, 5'b10010}; // X -..-
      8'h59: res.code = {3'd4, 5'b10110}; // Y -.--
      8'h5A: res.code = {3'd4, 5'b11000}; // Z --..
      8'h30: res.code = {3'd5, 5'b11111}; // 0
      8'h31: res.code = {3'd5, 5'b01111}; // 1
      8'h32: res.code = {3'd5, 5'b00111}; // 2
      8'h33: res.code = {3'd5, 5'b00011}; // 3
      8'h34: res.code = {3'd5, 5'b00001}; // 4
      8'h35: res.code = {3'd5, 5'b00000}; // 5
      8'h36: res.code = {3'd5, 5'b10000}; // 6
      8'h37: res.code = {3'd5, 5'b11000}; // 7
      8'h38: res.code = {3'd5, 5'b11100}; // 8
      8'h39: res.code = {3'd5, 5'b11110}; // 9
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Segment timer: counts TICK_RATE clocks per unit and flags the last clock of
// a segment of 'units' units. A restart zeroes both counters so every
// segment is measured from its own entry edge.
module morse_unit_timer #(
  parameter int TICK_RATE = 2500000,
  parameter int UNIT_W    = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              restart,
  input  logic [UNIT_W-1:0] units,
  output logic              done
);

  localparam int TICK_W = (TICK_RATE > 1) ? $clog2(TICK_RATE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_RATE - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic              tick_wrap_s;

  assign tick_wrap_s = (tick_q == TICK_LAST);
  assign done        = tick_wrap_s && (unit_q == (units - UNIT_W'(1)));

  // Advance the tick counter, wrapping at TICK_RATE-1 into the unit counter.
  always_comb begin
    tick_d = tick_q;
    unit_d = unit_q;
    if (restart) begin
      tick_d = '0;
      unit_d = '0;
    end else if (tick_wrap_s) begin
      tick_d = '0;
      unit_d = unit_q + UNIT_W'(1);
    end else begin
      tick_d = tick_q + TICK_W'(1);
      unit_d = unit_q;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_q <= '0;
      unit_q <= '0;
    end else begin
      tick_q <= tick_d;
      unit_q <= unit_d;
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Character-level Morse keyer: accepts ASCII over valid/ready and keys LED
// with ITU timing. Optional MORSE_FARNSWORTH_EN stretches the character and
// word gaps by GAP_STRETCH; otherwise GAP_STRETCH is ignored.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int TICK_RATE   = 2500000,
  parameter int GAP_STRETCH = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       LED,
  output logic       START,
  output logic       busy,
  output logic       err
);

  localparam int UNIT_W = $clog2(7 * GAP_STRETCH + 1);
`ifdef MORSE_FARNSWORTH_EN
  localparam int CHAR_GAP_EFF = CHAR_GAP_UNITS * GAP_STRETCH;
  localparam int WORD_GAP_EFF = WORD_EXTRA_UNITS * GAP_STRETCH;
`else
  localparam int CHAR_GAP_EFF = CHAR_GAP_UNITS;
  localparam int WORD_GAP_EFF = WORD_EXTRA_UNITS;
`endif

  morse_state_e  state_q, state_d;
  morse_code_t   code_q, code_d;
  logic [2:0]    elem_q, elem_d;
  logic          led_q, led_d, start_q, start_d, err_q, err_d;
  logic          busy_q, busy_d, ready_q, ready_d;
  morse_lookup_t lut_s;
  logic          accept_s, restart_s, done_s, dash_s;
  logic [4:0]    shifted_s;
  logic [UNIT_W-1:0] units_s;

  assign lut_s     = morse_lookup(char_in);
  assign accept_s  = (state_q == ST_IDLE) && ready_q && char_valid;
  assign shifted_s = code_q.bits << elem_q;
  assign dash_s    = shifted_s[4];
  assign restart_s = (state_d != state_q);

  // Segment length in units for the state currently being timed.
  always_comb begin
    units_s = UNIT_W'(DOT_UNITS);
    case (state_q)
      ST_MARK:     units_s = dash_s ? UNIT_W'(DASH_UNITS) : UNIT_W'(DOT_UNITS);
      ST_GAP_ELEM: units_s = UNIT_W'(ELEM_GAP_UNITS);
      ST_GAP_CHAR: units_s = UNIT_W'(CHAR_GAP_EFF);
      ST_GAP_WORD: units_s = UNIT_W'(WORD_GAP_EFF);
      default:     units_s = UNIT_W'(DOT_UNITS);
    endcase
  end

  morse_unit_timer #(
    .TICK_RATE (TICK_RATE),
    .UNIT_W    (UNIT_W)
  ) u_timer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .restart (restart_s),
    .units   (units_s),
    .done    (done_s)
  );

  // Next-state logic: sequence through elements and gaps of the held code.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    elem_d  = elem_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && lut_s.valid) begin
          code_d  = lut_s.code;
          elem_d  = 3'd0;
          state_d = (lut_s.code.len == 3'd0) ? ST_GAP_WORD : ST_MARK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MARK: begin
        if (done_s) begin
          if ((elem_q + 3'd1) < code_q.len) begin
            state_d = ST_GAP_ELEM;
            elem_d  = elem_q + 3'd1;
          end else begin
            state_d = ST_GAP_CHAR;
          end
        end else begin
          state_d = ST_MARK;
        end
      end
      ST_GAP_ELEM: begin
        if (done_s) begin
          state_d = ST_MARK;
        end else begin
          state_d = ST_GAP_ELEM;
        end
      end
      ST_GAP_CHAR, ST_GAP_WORD: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is registered.
  always_comb begin
    led_d   = (state_d == ST_MARK);
    start_d = (state_q == ST_IDLE) && (state_d == ST_MARK);
    err_d   = accept_s && !lut_s.valid;
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State, code holding and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      elem_q  <= 3'd0;
      led_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      elem_q  <= elem_d;
      led_q   <= led_d;
      start_q <= start_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign LED        = led_q;
  assign START      = start_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign char_ready = ready_q;

endmodule
